// File: rtl/module_top_deco_gray_n.sv
// Gray switches -> synchronised periodic sample -> binary LEDs and a multiplexed decimal 7-seg display.
// Build option DECO_GRAY_BLANK_ZEROS_EN blanks leading-zero digits; the default build shows every digit.
module module_top_deco_gray_n #(
    parameter int WIDTH           = 4,
    parameter int DIGITS          = 2,
    parameter int INPUT_REFRESH   = 2700000,
    parameter int DISPLAY_REFRESH = 27000
) (
    input  logic              clk_pi,
    input  logic              rst_pi,
    input  logic [WIDTH-1:0]  codigo_gray_pi,
    output logic [DIGITS-1:0] anodo_po,
    output logic [6:0]        catodo_po,
    output logic [WIDTH-1:0]  codigo_bin_led_po,
    output logic              ovf_po
);

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam int SW     = 4*DIGITS + 4;
    localparam int BW     = 4*DIGITS;
    localparam int SMP_W  = $clog2(INPUT_REFRESH);
    localparam int REF_W  = $clog2(DISPLAY_REFRESH + 1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W  = $clog2(WIDTH);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(INPUT_REFRESH - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(DISPLAY_REFRESH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int unsigned      MAXV     = pow10(DIGITS) - 1;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < WIDTH; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // One double-dabble step: +3 on every nibble >= 5, then shift left taking in the next source bit.
    function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] s, input logic b);
        logic [SW-1:0] t;
        t = s;
        for (int k = 0; k <= DIGITS; k++) begin
            if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
        end
        return (t << 1) | SW'(b);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

`ifdef DECO_GRAY_BLANK_ZEROS_EN
    function automatic logic lead_zero(input logic [BW-1:0] bcd, input logic [IDX_W-1:0] idx);
        logic nz;
        nz = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx) && bcd[4*k +: 4] != 4'd0) nz = 1'b1;
        end
        return (idx != '0) && !nz;
    endfunction
`endif

    // Stage p0/p1: two-flop synchroniser for the asynchronous switches
    logic [WIDTH-1:0] gray_p0_q, gray_p1_q;

    always_ff @(posedge clk_pi) begin
        gray_p0_q <= codigo_gray_pi;
        gray_p1_q <= gray_p0_q;
    end

    // Periodic sample with Gray->binary conversion
    logic [SMP_W-1:0] smp_cnt_q;
    logic [WIDTH-1:0] bin_q, bin_d, led_q;
    logic             smp_tick;

    assign smp_tick = (smp_cnt_q == SMP_LAST);
    assign bin_d    = gray2bin(gray_p1_q);

    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            smp_cnt_q <= '0;
            bin_q     <= '0;
            led_q     <= '1;
        end else begin
            smp_cnt_q <= smp_tick ? '0 : smp_cnt_q + 1'b1;
            if (smp_tick) begin
                bin_q <= bin_d;
                led_q <= ~bin_d;
            end
        end
    end

    // Sequential binary -> BCD conversion
    typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_t;

    state_t           state_q;
    logic             pend_q;
    logic [WIDTH-1:0] last_q, src_q;
    logic [SW-1:0]    scratch_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BW-1:0]    bcd_q;
    logic             ovf_q;

    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            state_q   <= ST_IDLE;
            pend_q    <= 1'b1;
            last_q    <= '0;
            src_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // pend_q forces the first conversion after reset even though bin_q == last_q
                    if (pend_q || bin_q != last_q) begin
                        pend_q    <= 1'b0;
                        last_q    <= bin_q;
                        src_q     <= bin_q;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    scratch_q <= dd_step(scratch_q, src_q[WIDTH-1]);
                    src_q     <= src_q << 1;
                    if (cnt_q == CNT_LAST) state_q <= ST_DONE;
                    else                   cnt_q   <= cnt_q + 1'b1;
                end
                ST_DONE: begin
                    bcd_q   <= scratch_q[BW-1:0];
                    ovf_q   <= (32'(last_q) > MAXV);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Digit scan driver
    logic [REF_W-1:0]  ref_cnt_q;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic              ref_tick, live_q;
    logic [3:0]        digit_d;
    logic [DIGITS-1:0] anodo_d, anodo_q;
    logic [6:0]        catodo_d, catodo_q;

    assign ref_tick = (ref_cnt_q == REF_LAST);
    assign idx_nxt  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    assign digit_d  = bcd_q[{idx_q, 2'b00} +: 4];
    assign anodo_d  = ~(DIGITS'(1) << idx_q);

    always_comb begin
        catodo_d = seg7(digit_d);
`ifdef DECO_GRAY_BLANK_ZEROS_EN
        if (lead_zero(bcd_q, idx_q)) catodo_d = 7'h7F;
`endif
        if (ovf_q) catodo_d = 7'h3F;
    end

    // The first terminal count only arms the display; later ones advance the digit index.
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            ref_cnt_q <= '0;
            idx_q     <= '0;
            live_q    <= 1'b0;
            anodo_q   <= '1;
            catodo_q  <= 7'h7F;
        end else begin
            ref_cnt_q <= ref_tick ? '0 : ref_cnt_q + 1'b1;
            if (ref_tick) begin
                live_q <= 1'b1;
                if (live_q) idx_q <= idx_nxt;
            end
            if (live_q) begin
                anodo_q  <= anodo_d;
                catodo_q <= catodo_d;
            end
        end
    end

    assign anodo_po          = anodo_q;
    assign catodo_po         = catodo_q;
    assign codigo_bin_led_po = led_q;
    assign ovf_po            = ovf_q;

endmodule

// File: tb/tb_module_top_deco_gray_n.sv
// Bench for module_top_deco_gray_n: a 3-digit and a 2-digit instance driven from the same switches.
module tb_module_top_deco_gray_n;

    localparam int W  = 8;
    localparam int IR = 4;
    localparam int DR = 2;
`ifdef DECO_GRAY_BLANK_ZEROS_EN
    localparam bit BLANK = 1'b1;
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam bit BLANK = 1'b0;
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gray = 8'h00;
    logic [2:0] anod3;
    logic [1:0] anod2;
    logic [6:0] cat3, cat2;
    logic [7:0] led3, led2;
    logic       ovf3, ovf2;

    module_top_deco_gray_n #(.WIDTH(W), .DIGITS(3), .INPUT_REFRESH(IR), .DISPLAY_REFRESH(DR)) dut3 (
        .clk_pi(clk), .rst_pi(rst), .codigo_gray_pi(gray),
        .anodo_po(anod3), .catodo_po(cat3), .codigo_bin_led_po(led3), .ovf_po(ovf3));

    module_top_deco_gray_n #(.WIDTH(W), .DIGITS(2), .INPUT_REFRESH(IR), .DISPLAY_REFRESH(DR)) dut2 (
        .clk_pi(clk), .rst_pi(rst), .codigo_gray_pi(gray),
        .anodo_po(anod2), .catodo_po(cat2), .codigo_bin_led_po(led2), .ovf_po(ovf2));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: decimal arithmetic straight from the display rules
    logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic int p10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b & 8'hFF;
    endfunction

    function automatic int exp_seg(input int v, input int k, input int nd);
        if (v > p10(nd) - 1) return 7'h3F;
        if (BLANK && k > 0 && v < p10(k)) return 7'h7F;
        return int'(SEG[(v / p10(k)) % 10]);
    endfunction

    function automatic int bcd_of(input int v);
        int r = 0;
        for (int k = 0; k < 3; k++) r = r | (((v / p10(k)) % 10) << (4*k));
        return r;
    endfunction

    logic [6:0] seen3 [3];
    logic [6:0] seen2 [2];
    bit         got3  [3];
    bit         got2  [2];
    int         bad_anode;

    task automatic observe();
        for (int k = 0; k < 3; k++) got3[k] = 1'b0;
        for (int k = 0; k < 2; k++) got2[k] = 1'b0;
        bad_anode = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if ($countones(~anod3) != 1) bad_anode++;
            if ($countones(~anod2) != 1) bad_anode++;
            for (int k = 0; k < 3; k++)
                if (anod3 == ~(3'b001 << k)) begin seen3[k] = cat3; got3[k] = 1'b1; end
            for (int k = 0; k < 2; k++)
                if (anod2 == ~(2'b01 << k)) begin seen2[k] = cat2; got2[k] = 1'b1; end
        end
    endtask

    task automatic check_dut2(input string tag, input int v);
        chk($sformatf("%s led2", tag), int'(led2), (~v) & 8'hFF);
        chk($sformatf("%s ovf2", tag), int'(ovf2), (v > 99) ? 1 : 0);
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s dut2 digit%0d", tag, k), got2[k] ? int'(seen2[k]) : -1, exp_seg(v, k, 2));
        chk($sformatf("%s anode shape", tag), bad_anode, 0);
    endtask

    task automatic check_model(input string tag, input int v);
        chk($sformatf("%s led3", tag), int'(led3), (~v) & 8'hFF);
        chk($sformatf("%s ovf3", tag), int'(ovf3), (v > 999) ? 1 : 0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s dut3 digit%0d", tag, k), got3[k] ? int'(seen3[k]) : -1, exp_seg(v, k, 3));
        check_dut2(tag, v);
    endtask

    typedef struct {
        logic [7:0] gray;
        logic [7:0] led;
        logic       ovf;
        logic [6:0] s0, s1, s2;
    } vec_t;

    vec_t tbl [8];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int v, k, old, cnt, changes;
        bit found, hit;
        bit seen_v [256];
        logic [6:0] rel_cat [8];
        logic [2:0] rel_an  [8];

        tbl[0] = '{8'h80, 8'h00, 1'b0, 7'h12, 7'h12, 7'h24};
        tbl[1] = '{8'h0D, 8'hF6, 1'b0, 7'h10, LZ,    LZ   };
        tbl[2] = '{8'h56, 8'h9B, 1'b0, 7'h40, 7'h40, 7'h79};
        tbl[3] = '{8'h52, 8'h9C, 1'b0, 7'h10, 7'h10, LZ   };
        tbl[4] = '{8'h00, 8'hFF, 1'b0, 7'h40, LZ,    LZ   };
        tbl[5] = '{8'h07, 8'hFA, 1'b0, 7'h12, LZ,    LZ   };
        tbl[6] = '{8'h38, 8'hD0, 1'b0, 7'h78, 7'h19, LZ   };
        tbl[7] = '{8'hEE, 8'h4B, 1'b0, 7'h40, 7'h00, 7'h79};
        rel_an  = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b101, 3'b101, 3'b011, 3'b011};
        rel_cat = '{7'h7F,  7'h7F,  7'h40,  7'h40,  LZ,     LZ,     LZ,     LZ    };

        // Reset held three cycles, then the first scan sequence
        rst = 1'b1;
        gray = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset anodo3", int'(anod3), 3'b111);
        chk("reset catodo3", int'(cat3), 7'h7F);
        chk("reset led3", int'(led3), 8'hFF);
        chk("reset ovf3", int'(ovf3), 0);
        chk("reset anodo2", int'(anod2), 2'b11);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("release anodo[%0d]", i), int'(anod3), int'(rel_an[i]));
            chk($sformatf("release catodo[%0d]", i), int'(cat3), int'(rel_cat[i]));
        end

        // Directed table
        for (int i = 0; i < 8; i++) begin
            gray = tbl[i].gray;
            repeat (30) @(negedge clk);
            chk($sformatf("tbl%0d led3", i), int'(led3), int'(tbl[i].led));
            chk($sformatf("tbl%0d ovf3", i), int'(ovf3), int'(tbl[i].ovf));
            observe();
            chk($sformatf("tbl%0d digit0", i), got3[0] ? int'(seen3[0]) : -1, int'(tbl[i].s0));
            chk($sformatf("tbl%0d digit1", i), got3[1] ? int'(seen3[1]) : -1, int'(tbl[i].s1));
            chk($sformatf("tbl%0d digit2", i), got3[2] ? int'(seen3[2]) : -1, int'(tbl[i].s2));
            check_dut2($sformatf("tbl%0d", i), g2b(int'(tbl[i].gray)));
        end

        // Random values against the model
        for (int i = 0; i < 12; i++) begin
            gray = 8'($urandom_range(0, 255));
            repeat (30) @(negedge clk);
            observe();
            check_model($sformatf("rnd%0d", i), g2b(int'(gray)));
        end

        // Latency from a bin_q change to the BCD update
        gray = 8'h0D;
        repeat (30) @(negedge clk);
        gray = 8'h80;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (led3 == 8'h00) hit = 1'b1;
        end
        chk("latency sample seen", int'(hit), 1);
        old = int'(dut3.bcd_q);
        cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (int'(dut3.bcd_q) != old) begin cnt = c; break; end
        end
        chk("latency cycles", cnt, W + 2);
        chk("latency bcd", int'(dut3.bcd_q), 12'h255);

        // Input changing every cycle: every BCD result must be the exact BCD of a sampled value
        for (int j = 0; j < 256; j++) seen_v[j] = 1'b0;
        seen_v[(~led3) & 8'hFF] = 1'b1;
        old = int'(dut3.bcd_q);
        changes = 0;
        for (int c = 0; c < 60; c++) begin
            gray = 8'($urandom_range(0, 255));
            @(negedge clk);
            seen_v[(~led3) & 8'hFF] = 1'b1;
            if (int'(dut3.bcd_q) != old) begin
                old = int'(dut3.bcd_q);
                changes++;
                found = 1'b0;
                for (int j = 0; j < 256; j++) if (seen_v[j] && bcd_of(j) == old) found = 1'b1;
                chk($sformatf("churn exact bcd %0d", changes), int'(found), 1);
            end
        end
        repeat (30) @(negedge clk);
        v = g2b(int'(gray));
        chk("churn final bcd", int'(dut3.bcd_q), bcd_of(v));
        observe();
        check_model("churn final", v);

        // Reset in the middle of a conversion
        gray = 8'h80;
        repeat (30) @(negedge clk);
        gray = 8'h38;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (led3 == 8'hD0) hit = 1'b1;
        end
        chk("midconv sample seen", int'(hit), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        gray = 8'h00;
        @(negedge clk);
        chk("midconv anodo3", int'(anod3), 3'b111);
        chk("midconv catodo3", int'(cat3), 7'h7F);
        chk("midconv led3", int'(led3), 8'hFF);
        chk("midconv ovf3", int'(ovf3), 0);
        chk("midconv bcd", int'(dut3.bcd_q), 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        observe();
        check_model("after midconv reset", 0);

        k = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
